pwm_duty_sched: RTL
===================

# pwm_duty_sched

Controller that sequences the duty-cycle setting of the 10-step PWM datapath. It synchronises and debounces two push-button inputs (increase and decrease) and holds each resulting request as pending. It applies pending requests only at a PWM period boundary, so no period is ever truncated, and it runs an automatic up/down duty sweep on request. It sits between the `ui_in` pins and the PWM counter/comparator and drives that datapath's duty input.

## Interface
Parameters:
- `PERIOD`, 10: PWM steps per period; sets the legal duty range.
- `DUTY_W`, 4: duty bus width; must satisfy 2^DUTY_W > PERIOD.
- `DUTY_RST`, 5: duty value after reset and after a completed sweep.
- `DUTY_MIN`, 1: lowest duty value.
- `DUTY_MAX`, 9: highest duty value (PERIOD-1).
- `DEB_CYCLES`, 4: consecutive stable cycles needed to accept a button level (used only when `PWM_DEBOUNCE_EN` is defined).

Ports:
- `clk`, input, 1: sole clock.
- `rst_n`, input, 1: reset, **asynchronous, active-low**.
- `ena`, input, 1: global enable; low freezes all control state.
- `inc_btn`, input, 1: raw increase button, asynchronous.
- `dec_btn`, input, 1: raw decrease button, asynchronous.
- `sweep_req`, input, 1: synchronous one-cycle pulse that starts a sweep.
- `period_wrap`, input, 1: from the datapath; high in the cycle its counter equals PERIOD-1.
- `duty`, output, DUTY_W: registered duty setting fed to the comparator.
- `duty_load`, output, 1: one-cycle pulse in the cycle after `duty` changes.
- `busy`, output, 1: high while a sweep is active.

## Operation
- **Input front end**: each button passes through a 2-FF synchroniser, then the optional debouncer, then a rising-edge detector. A detected edge sets the matching pending flag, `pend_inc` or `pend_dec`.
- **Pending flags**: while a flag is already set, further edges are absorbed (at most one step per period). Flags clear at the next `period_wrap` in every case.
- **Applying requests in IDLE** (all at the `period_wrap` edge):
  - only `pend_inc`: duty = min(duty+1, DUTY_MAX).
  - only `pend_dec`: duty = max(duty-1, DUTY_MIN).
  - both flags set: no change.
- **Saturation**: an increment at DUTY_MAX or a decrement at DUTY_MIN clears its flag, leaves `duty` unchanged and does not pulse `duty_load`.
- **Sweep FSM** (states IDLE, UP, DOWN, RESTORE), one step per `period_wrap`:
  - IDLE → UP on `sweep_req`; `busy` = 1 in every state except IDLE.
  - UP: duty+1 per wrap; when duty reaches DUTY_MAX, go to DOWN.
  - DOWN: duty-1 per wrap; when duty reaches DUTY_MIN, go to RESTORE.
  - RESTORE: at the next wrap, duty = DUTY_RST and the FSM returns to IDLE.
- **Sweep entry at DUTY_MAX**: a sweep started with duty already at DUTY_MAX enters UP, and the first wrap only moves the FSM to DOWN.
- **Abort**: any button edge during a sweep aborts it. The FSM goes to IDLE immediately, `busy` falls the next cycle and `duty` keeps its current value. The aborting edge still sets its pending flag, which is applied at the next wrap.
- **`sweep_req` while busy**: ignored.
- **Same-cycle `sweep_req` and button edge in IDLE**: the button wins and the sweep does not start.
- **`ena` low**:
  - Held: FSM, duty and pending flags.
  - Still running: synchroniser and debouncer.
  - Discarded: edges and `sweep_req`.
  - `duty_load` is 0.
- **Duty arithmetic**: unsigned, DUTY_W bits; values never leave the range [DUTY_MIN, DUTY_MAX].

## Timing
- **Reset values**: `duty` = DUTY_RST, `duty_load` = 0, `busy` = 0, FSM = IDLE, pending flags cleared, synchronisers cleared. Reset asserted mid-sweep returns everything to these values immediately (asynchronously).
- **Button to pending flag**: 3 cycles from the first clock edge that samples the button high without debounce; DEB_CYCLES+3 with debounce.
- **Pending flag to `duty`**: `duty` updates at the first clock edge where `period_wrap` = 1 is sampled, which is also the edge where the pending flag is cleared.
- **`duty_load`**: high for exactly the one cycle following each edge that changes `duty`.
- **Edge coinciding with `period_wrap`**: an edge detected in the same cycle as `period_wrap` is applied at the following wrap, not the current one.

## Configuration
- Macro `PWM_DEBOUNCE_EN`.
- **Defined**: a per-button counter requires the synchronised level to be stable for DEB_CYCLES consecutive cycles before the debounced level changes. Any toggle restarts the count.
- **Undefined**: the synchronised level feeds the edge detector directly; the counters and the DEB_CYCLES logic are absent.

## Structure
- **Shared package** `pwm_pkg`: the sweep-state enum (IDLE, UP, DOWN, RESTORE) and the default constants PERIOD, DUTY_RST, DUTY_MIN and DUTY_MAX.
- **One sub-module** `btn_cond`: 2-FF synchroniser, optional debouncer and rising-edge pulse. It is instantiated twice, once for `inc_btn` and once for `dec_btn`.

## Test plan
- **Reset**: assert `rst_n` low mid-sweep → `duty` = 5, `busy` = 0 and `duty_load` = 0 with no clock needed.
- **Single press**: hold `inc_btn` high for 10 cycles (debounce on) with `period_wrap` every 10 cycles → `duty` goes 5→6 at exactly one wrap, with `duty_load` high for exactly one cycle.
- **Debounce rejection and saturation**:
  - `inc_btn` glitching high for 2 cycles → no change.
  - Four valid presses starting from 5 → `duty` saturates at 9.
  - A fifth press → `duty` stays 9 with no `duty_load`.
- **Simultaneous presses**: inc and dec edges in the same period → `duty` unchanged and both flags cleared at the wrap.
- **Full sweep**: `sweep_req` from duty 5 → duty steps 6,7,8,9,8,…,1 then 5, one step per wrap; `busy` falls in the cycle after the final value of 5 is loaded.
- **Abort and freeze**:
  - Press `dec_btn` during UP at duty 7 → `busy` drops and the next wrap gives duty 6.
  - Hold `ena` low across 3 wraps → `duty` is constant.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and default constants for the PWM duty controller.
// Holds the sweep-state enum and the default period/duty limits.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      UP,
      DOWN,
      RESTORE
   } sweep_st_t;

   localparam int PERIOD   = 10;
   localparam int DUTY_RST = 5;
   localparam int DUTY_MIN = 1;
   localparam int DUTY_MAX = 9;

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-FF synchroniser, optional debouncer, rise pulse.
// Ports: clk, rst_n, btn (raw async), rise (1-cycle pulse). Macro PWM_DEBOUNCE_EN.
module btn_cond #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   logic s1;
   logic s2;
   logic lvl;
   logic lvl_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;
      end
   end

`ifdef PWM_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [CW-1:0] cnt;
   logic          deb;

   // Count cycles the synced level differs from the accepted level;
   // falling back to the accepted level restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         deb <= 1'b0;
      end else if (s2 == deb) begin
         cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
         cnt <= '0;
         deb <= s2;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign lvl = deb;
`else
   assign lvl = s2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_d <= 1'b0;
         rise  <= 1'b0;
      end else begin
         lvl_d <= lvl;
         rise  <= lvl & ~lvl_d;
      end
   end

endmodule

// File: rtl/pwm_duty_sched.sv
// Duty-cycle scheduler: button requests and auto sweep, applied at wraps.
// Ports: clk, rst_n, ena, inc_btn, dec_btn, sweep_req, period_wrap -> duty, duty_load, busy.
// Optional debounce via macro PWM_DEBOUNCE_EN.
module pwm_duty_sched
   import pwm_pkg::*;
#(
   parameter int PERIOD     = pwm_pkg::PERIOD,
   parameter int DUTY_W     = 4,
   parameter int DUTY_RST   = pwm_pkg::DUTY_RST,
   parameter int DUTY_MIN   = pwm_pkg::DUTY_MIN,
   parameter int DUTY_MAX   = pwm_pkg::DUTY_MAX,
   parameter int DEB_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              inc_btn,
   input  logic              dec_btn,
   input  logic              sweep_req,
   input  logic              period_wrap,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_load,
   output logic              busy
);

   localparam logic [DUTY_W-1:0] D_RST = DUTY_W'(DUTY_RST);
   localparam logic [DUTY_W-1:0] D_MIN = DUTY_W'(DUTY_MIN);
   localparam logic [DUTY_W-1:0] D_MAX = DUTY_W'(DUTY_MAX);

   sweep_st_t         st;
   sweep_st_t         st_nxt;
   logic [DUTY_W-1:0] duty_nxt;
   logic              inc_rise;
   logic              dec_rise;
   logic              inc_e;
   logic              dec_e;
   logic              sw_e;
   logic              abort;
   logic              pend_inc;
   logic              pend_dec;

   btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (inc_btn),
      .rise (inc_rise)
   );

   btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_dec (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (dec_btn),
      .rise (dec_rise)
   );

   assign inc_e = inc_rise & ena;
   assign dec_e = dec_rise & ena;
   assign sw_e  = sweep_req & ena;
   assign abort = inc_e | dec_e;
   assign busy  = (st != IDLE);

   always_comb begin
      st_nxt   = st;
      duty_nxt = duty;
      unique case (st)
         IDLE: begin
            if (period_wrap) begin
               if (pend_inc && !pend_dec && duty < D_MAX)
                  duty_nxt = duty + 1'b1;
               else if (pend_dec && !pend_inc && duty > D_MIN)
                  duty_nxt = duty - 1'b1;
            end
            // a button edge in the same cycle suppresses the sweep
            if (sw_e && !abort)
               st_nxt = UP;
         end
         UP: begin
            if (abort) begin
               st_nxt = IDLE;
            end else if (period_wrap) begin
               if (duty >= D_MAX) begin
                  st_nxt = DOWN;
               end else begin
                  duty_nxt = duty + 1'b1;
                  if (duty + 1'b1 == D_MAX)
                     st_nxt = DOWN;
               end
            end
         end
         DOWN: begin
            if (abort) begin
               st_nxt = IDLE;
            end else if (period_wrap) begin
               if (duty <= D_MIN) begin
                  st_nxt = RESTORE;
               end else begin
                  duty_nxt = duty - 1'b1;
                  if (duty - 1'b1 == D_MIN)
                     st_nxt = RESTORE;
               end
            end
         end
         RESTORE: begin
            if (abort) begin
               st_nxt = IDLE;
            end else if (period_wrap) begin
               duty_nxt = D_RST;
               st_nxt   = IDLE;
            end
         end
         default: st_nxt = IDLE;
      endcase
   end

   // An edge seen on the wrap itself survives the clear and waits
   // for the following wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         duty      <= D_RST;
         duty_load <= 1'b0;
         pend_inc  <= 1'b0;
         pend_dec  <= 1'b0;
      end else if (ena) begin
         st        <= st_nxt;
         duty      <= duty_nxt;
         duty_load <= (duty_nxt != duty);
         pend_inc  <= period_wrap ? inc_e : (pend_inc | inc_e);
         pend_dec  <= period_wrap ? dec_e : (pend_dec | dec_e);
      end else begin
         duty_load <= 1'b0;
      end
   end

endmodule
